// File: rtl/x_stream_gen.sv
// x_stream_gen: serialises a loaded bit pattern onto x, LSB first.
// Each bit is held for HOLD cycles. A pass can run once or repeat, with an
// optional idle gap between passes. Every output comes straight from a flop.
module x_stream_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             x,
  output logic             valid,
  output logic             ready,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx
);

  // Counters need at least one bit, even when HOLD or GAP is 0 or 1.
  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GC_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(HOLD - 1);
  localparam logic [GC_W-1:0]  GAP_MAX  = GC_W'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [GC_W-1:0]  gap_q, gap_d;
  logic [WIDTH-1:0] pat_q, pat_d;   // stored copy, used to restart a pass
  logic [WIDTH-1:0] sh_q, sh_d;     // working copy; bit 0 is the bit on x
  logic [LEN_W-1:0] len_q, len_d;

  logic [WIDTH-1:0] sh_shift;
  logic [LEN_W-1:0] len_clamped;

  // A shift register replaces a variable index into the pattern.
  assign sh_shift    = sh_q >> 1;
  assign len_clamped = (len > WIDTH_L) ? WIDTH_L : len;

  // Compute the next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    valid_d = valid_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    len_d   = len_q;

    case (state_q)
      ST_IDLE: begin
        x_d     = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b1;
        idx_d   = '0;
        if (load && ready_q && !abort) begin
          if (len_clamped == '0) begin
            // Empty pass: nothing is sent, but the pass still reports done.
            done_d = 1'b1;
          end else begin
            pat_d   = pattern;
            sh_d    = pattern;
            len_d   = len_clamped;
            state_d = ST_SEND;
            x_d     = pattern[0];
            valid_d = 1'b1;
            ready_d = 1'b0;
            hold_d  = '0;
          end
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_d     = 1'b0;
          valid_d = 1'b0;
          ready_d = 1'b1;
          idx_d   = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_MAX) begin
          hold_d = '0;
          if ((idx_q + LEN_W'(1)) < len_q) begin
            idx_d = idx_q + LEN_W'(1);
            sh_d  = sh_shift;
            x_d   = sh_shift[0];
          end else begin
            // End of pass: repeat_en is only looked at here.
            done_d = 1'b1;
            idx_d  = '0;
            if (repeat_en) begin
              if (GAP == 0) begin
                sh_d = pat_q;
                x_d  = pat_q[0];
              end else begin
                state_d = ST_GAP;
                gap_d   = '0;
                x_d     = 1'b0;
                valid_d = 1'b0;
              end
            end else begin
              state_d = ST_IDLE;
              x_d     = 1'b0;
              valid_d = 1'b0;
              ready_d = 1'b1;
            end
          end
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_d     = 1'b0;
          valid_d = 1'b0;
          ready_d = 1'b1;
          idx_d   = '0;
          gap_d   = '0;
        end else if (gap_q == GAP_MAX) begin
          state_d = ST_SEND;
          sh_d    = pat_q;
          x_d     = pat_q[0];
          valid_d = 1'b1;
          idx_d   = '0;
          hold_d  = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GC_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        x_d     = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b1;
        idx_d   = '0;
      end
    endcase
  end

  // Register all state and outputs; RESET overrides everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      idx_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
    end
  end

  assign x       = x_q;
  assign valid   = valid_q;
  assign ready   = ready_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule
